// File: rtl/nyakuo_pkg.sv
// nyakuo_pkg: shared types and constants for the nyakuo RV32I core.
//   instruction : decoded operation enum (ILLEGAL encodes as 0)
//   decoded_t   : {inst, operand_a, operand_b, rd} bundle from decode to execute
//   OP_*        : major opcodes handled by the decode stage
package nyakuo_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;

  localparam logic [6:0] OP_REG = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  // funct7 values that select the base and alternate (SUB/SRA) variants
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [4:0] {
    ILLEGAL = 5'd0,
    ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
    ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
    LUI
  } instruction;

  typedef struct packed {
    instruction        inst;
    logic [XLEN-1:0]   operand_a;
    logic [XLEN-1:0]   operand_b;
    logic [4:0]        rd;
  } decoded_t;

  localparam decoded_t DECODED_NONE = '{inst: ILLEGAL, operand_a: '0, operand_b: '0, rd: '0};

  // I-type immediate, sign-extended to XLEN
  function automatic logic [XLEN-1:0] imm_i(input logic [31:0] instr);
    return {{20{instr[31]}}, instr[31:20]};
  endfunction

endpackage

// File: rtl/regfile.sv
// regfile: 32x32 integer register file.
//   clk_i, rst_i            : clock, asynchronous active-high reset (clears all entries)
//   we_i, waddr_i, wdata_i  : synchronous write port; writes to x0 are dropped
//   raddr_a_i / rdata_a_o   : asynchronous read port A
//   raddr_b_i / rdata_b_o   : asynchronous read port B
// A read of the register being written in the same cycle returns wdata_i.
module regfile
  import nyakuo_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            we_i,
  input  logic [4:0]      waddr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [4:0]      raddr_a_i,
  input  logic [4:0]      raddr_b_i,
  output logic [XLEN-1:0] rdata_a_o,
  output logic [XLEN-1:0] rdata_b_o
);

  logic [XLEN-1:0] mem_q [NREGS];
  logic [XLEN-1:0] mem_d [NREGS];

  always_comb begin
    // NOTE: start from the current contents so every path assigns mem_d; a missing default would infer a latch.
    mem_d = mem_q;
    if (we_i && (waddr_i != 5'd0)) begin
      mem_d[waddr_i] = wdata_i;
    end
  end

  // NOTE: the array is reset as a whole because the core relies on every register reading 0 out of reset;
  // this forces flops rather than a RAM macro, which is acceptable at 32 entries.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREGS; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      // NOTE: state is updated with <= so all flops sample their _d values at the same edge.
      mem_q <= mem_d;
    end
  end

  always_comb begin
    rdata_a_o = '0;
    if (raddr_a_i != 5'd0) begin
      rdata_a_o = (we_i && (waddr_i == raddr_a_i)) ? wdata_i : mem_q[raddr_a_i];
    end
  end

  always_comb begin
    rdata_b_o = '0;
    if (raddr_b_i != 5'd0) begin
      rdata_b_o = (we_i && (waddr_i == raddr_b_i)) ? wdata_i : mem_q[raddr_b_i];
    end
  end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: RV32I decode for the nyakuo core (R-type ALU, I-type ALU, LUI).
//   clk_i, rst_i                  : clock, asynchronous active-high reset
//   instr_valid_i/instr_ready_o   : fetch handshake for instr_i
//   instr_i                       : raw instruction word
//   wb_en_i, wb_rd_i, wb_data_i   : register write-back, bypassed into operand reads
//   valid_o/ready_i               : registered handshake toward execute
//   inst_o, operand_a_o, operand_b_o, rd_o : decoded bundle
module decode_stage
  import nyakuo_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            instr_valid_i,
  output logic            instr_ready_o,
  input  logic [31:0]     instr_i,
  input  logic            wb_en_i,
  input  logic [4:0]      wb_rd_i,
  input  logic [XLEN-1:0] wb_data_i,
  output logic            valid_o,
  input  logic            ready_i,
  output instruction      inst_o,
  output logic [XLEN-1:0] operand_a_o,
  output logic [XLEN-1:0] operand_b_o,
  output logic [4:0]      rd_o
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rs1, rs2, rd;
  logic [XLEN-1:0] rs1_val, rs2_val;

  assign opcode = instr_i[6:0];
  assign rd     = instr_i[11:7];
  assign funct3 = instr_i[14:12];
  assign rs1    = instr_i[19:15];
  assign rs2    = instr_i[24:20];
  assign funct7 = instr_i[31:25];

  regfile u_regfile (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .we_i      (wb_en_i),
    .waddr_i   (wb_rd_i),
    .wdata_i   (wb_data_i),
    .raddr_a_i (rs1),
    .raddr_b_i (rs2),
    .rdata_a_o (rs1_val),
    .rdata_b_o (rs2_val)
  );

  decoded_t dec;

  always_comb begin
    dec = DECODED_NONE;
    case (opcode)
      OP_REG: begin
        dec.operand_a = rs1_val;
        dec.operand_b = rs2_val;
        dec.rd        = rd;
        if (funct7 == F7_BASE) begin
          case (funct3)
            3'b000:  dec.inst = ADD;
            3'b001:  dec.inst = SLL;
            3'b010:  dec.inst = SLT;
            3'b011:  dec.inst = SLTU;
            3'b100:  dec.inst = XOR;
            3'b101:  dec.inst = SRL;
            3'b110:  dec.inst = OR;
            default: dec.inst = AND;
          endcase
        end else if (funct7 == F7_ALT) begin
          case (funct3)
            3'b000:  dec.inst = SUB;
            3'b101:  dec.inst = SRA;
            default: dec.inst = ILLEGAL;
          endcase
        end
      end
      OP_IMM: begin
        dec.operand_a = rs1_val;
        dec.operand_b = imm_i(instr_i);
        dec.rd        = rd;
        case (funct3)
          3'b000: dec.inst = ADDI;
          3'b010: dec.inst = SLTI;
          3'b011: dec.inst = SLTIU;
          3'b100: dec.inst = XORI;
          3'b110: dec.inst = ORI;
          3'b111: dec.inst = ANDI;
          3'b001: begin
            dec.operand_b = {27'b0, rs2};
            if (funct7 == F7_BASE) dec.inst = SLLI;
          end
          default: begin
            dec.operand_b = {27'b0, rs2};
            if (funct7 == F7_BASE)     dec.inst = SRLI;
            else if (funct7 == F7_ALT) dec.inst = SRAI;
          end
        endcase
      end
      OP_LUI: begin
        dec.inst      = LUI;
        dec.operand_b = {instr_i[31:12], 12'b0};
        dec.rd        = rd;
      end
      default: dec = DECODED_NONE;
    endcase
    // Any unrecognised encoding leaves ILLEGAL; zero the rest of the bundle so execute sees a clean no-op.
    if (dec.inst == ILLEGAL) dec = DECODED_NONE;
  end

  logic     valid_q, valid_d;
  decoded_t bundle_q, bundle_d;
  logic     accept;

  assign instr_ready_o = !valid_q || ready_i;
  assign accept        = instr_valid_i && instr_ready_o;

  always_comb begin
    valid_d  = valid_q;
    bundle_d = bundle_q;
    if (accept) begin
      valid_d  = 1'b1;
      bundle_d = dec;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q  <= 1'b0;
      bundle_q <= DECODED_NONE;
    end else begin
      valid_q  <= valid_d;
      bundle_q <= bundle_d;
    end
  end

  assign valid_o     = valid_q;
  assign inst_o      = bundle_q.inst;
  assign operand_a_o = bundle_q.operand_a;
  assign operand_b_o = bundle_q.operand_b;
  assign rd_o        = bundle_q.rd;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: self-checking bench for decode_stage.
// Directed scenarios use hand-computed constants; the randomized scenario builds each
// instruction from a chosen mnemonic and predicts the bundle from that choice.
module tb_decode_stage;
  import nyakuo_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        instr_valid_i = 1'b0;
  logic        instr_ready_o;
  logic [31:0] instr_i = '0;
  logic        wb_en_i = 1'b0;
  logic [4:0]  wb_rd_i = '0;
  logic [31:0] wb_data_i = '0;
  logic        valid_o;
  logic        ready_i = 1'b0;
  instruction  inst_o;
  logic [31:0] operand_a_o;
  logic [31:0] operand_b_o;
  logic [4:0]  rd_o;

  int tests = 0;
  int fails = 0;

  decode_stage dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .instr_valid_i (instr_valid_i),
    .instr_ready_o (instr_ready_o),
    .instr_i       (instr_i),
    .wb_en_i       (wb_en_i),
    .wb_rd_i       (wb_rd_i),
    .wb_data_i     (wb_data_i),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .inst_o        (inst_o),
    .operand_a_o   (operand_a_o),
    .operand_b_o   (operand_b_o),
    .rd_o          (rd_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  // ---------------- reference model state ----------------
  logic [31:0] rf_m [32];
  bit          m_valid;
  decoded_t    m_bundle;

  localparam instruction  R_OPS [10] = '{ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND};
  localparam logic [2:0]  R_F3  [10] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5, 3'd6, 3'd7};
  localparam bit          R_ALT [10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  localparam instruction  I_OPS [6]  = '{ADDI, SLTI, SLTIU, XORI, ORI, ANDI};
  localparam logic [2:0]  I_F3  [6]  = '{3'd0, 3'd2, 3'd3, 3'd4, 3'd6, 3'd7};
  localparam logic [2:0]  BAD_ALT_F3 [6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd6, 3'd7};
  localparam logic [6:0]  OTHER_OPS [5] = '{7'b1101111, 7'b0000011, 7'b0100011, 7'b1100011, 7'b0010111};

  function automatic logic [31:0] read_m(input logic [4:0] r, input bit wbe,
                                         input logic [4:0] wrd, input logic [31:0] wdat);
    if (r == 5'd0) return 32'd0;
    if (wbe && wrd == r) return wdat;
    return rf_m[r];
  endfunction

  task automatic set_in(input bit iv, input logic [31:0] ins, input bit wbe,
                        input logic [4:0] wrd, input logic [31:0] wdat, input bit rdy);
    instr_valid_i = iv;
    instr_i       = ins;
    wb_en_i       = wbe;
    wb_rd_i       = wrd;
    wb_data_i     = wdat;
    ready_i       = rdy;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Pick a mnemonic, encode it, and state what the stage must produce for it.
  task automatic gen(input bit wbe, input logic [4:0] wrd, input logic [31:0] wdat,
                     output logic [31:0] ins, output decoded_t exp);
    int          k, j;
    logic [4:0]  rd, rs1, rs2;
    logic [11:0] imm;
    logic [19:0] u;
    logic [31:0] r;
    k   = int'($urandom_range(0, 23));
    rd  = 5'($urandom);
    rs1 = 5'($urandom);
    rs2 = 5'($urandom);
    imm = 12'($urandom);
    u   = 20'($urandom);
    exp = '{inst: ILLEGAL, operand_a: 32'd0, operand_b: 32'd0, rd: 5'd0};
    if (k < 10) begin
      ins = {(R_ALT[k] ? 7'h20 : 7'h00), rs2, rs1, R_F3[k], rd, OP_REG};
      exp = '{inst: R_OPS[k], operand_a: read_m(rs1, wbe, wrd, wdat),
              operand_b: read_m(rs2, wbe, wrd, wdat), rd: rd};
    end else if (k < 16) begin
      j   = k - 10;
      ins = {imm, rs1, I_F3[j], rd, OP_IMM};
      exp = '{inst: I_OPS[j], operand_a: read_m(rs1, wbe, wrd, wdat),
              operand_b: {{20{imm[11]}}, imm}, rd: rd};
    end else if (k < 19) begin
      j = k - 16;
      ins = {(j == 2 ? 7'h20 : 7'h00), rs2, rs1, (j == 0 ? 3'd1 : 3'd5), rd, OP_IMM};
      exp = '{inst: (j == 0 ? SLLI : (j == 1 ? SRLI : SRAI)),
              operand_a: read_m(rs1, wbe, wrd, wdat), operand_b: {27'd0, rs2}, rd: rd};
    end else if (k == 19) begin
      ins = {u, rd, OP_LUI};
      exp = '{inst: LUI, operand_a: 32'd0, operand_b: {u, 12'd0}, rd: rd};
    end else if (k == 20) begin
      ins = {7'h01, rs2, rs1, R_F3[$urandom_range(0, 9)], rd, OP_REG};
    end else if (k == 21) begin
      ins = {7'h20, rs2, rs1, BAD_ALT_F3[$urandom_range(0, 5)], rd, OP_REG};
    end else if (k == 22) begin
      r   = $urandom;
      ins = {r[31:7], OTHER_OPS[$urandom_range(0, 4)]};
    end else begin
      ins = {7'h01, rs2, rs1, 3'd5, rd, OP_IMM};
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    set_in(0, 32'd0, 0, 5'd0, 32'd0, 0);
    rst_i = 1'b1;
    #13;
    tests++; if (instr_ready_o !== 1'b1) begin fails++; $display("FAIL reset_ready: got %0b want 1", instr_ready_o); end
    tests++; if (valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid: got %0b want 0", valid_o); end
    tests++; if (inst_o !== ILLEGAL) begin fails++; $display("FAIL reset_inst: got %0d want %0d", inst_o, ILLEGAL); end
    tests++; if ({operand_a_o, operand_b_o, rd_o} !== 69'd0) begin fails++;
      $display("FAIL reset_bundle: got a=%h b=%h rd=%0d want all 0", operand_a_o, operand_b_o, rd_o); end
    @(negedge clk_i);
    rst_i = 1'b0;
    tick();
    tests++; if (instr_ready_o !== 1'b1 || valid_o !== 1'b0) begin fails++;
      $display("FAIL post_reset: got ready=%0b valid=%0b want 1/0", instr_ready_o, valid_o); end
  endtask

  task automatic test_addi();
    set_in(1, 32'h00500093, 0, 5'd0, 32'd0, 1);
    tick();
    tests++; if (valid_o !== 1'b1) begin fails++; $display("FAIL addi_valid: got %0b want 1", valid_o); end
    tests++; if (inst_o !== ADDI) begin fails++; $display("FAIL addi_inst: got %0d want %0d", inst_o, ADDI); end
    tests++; if (operand_a_o !== 32'd0 || operand_b_o !== 32'd5 || rd_o !== 5'd1) begin fails++;
      $display("FAIL addi_bundle: got a=%h b=%h rd=%0d want 0/5/1", operand_a_o, operand_b_o, rd_o); end
    set_in(0, 32'd0, 0, 5'd0, 32'd0, 1);
    tick();
    tests++; if (valid_o !== 1'b0) begin fails++; $display("FAIL addi_drain: got %0b want 0", valid_o); end
  endtask

  task automatic test_sub_bypass();
    set_in(0, 32'd0, 1, 5'd2, 32'h10, 1); tick();
    set_in(0, 32'd0, 1, 5'd3, 32'h3, 1);  tick();
    set_in(1, 32'h403100B3, 1, 5'd3, 32'h7, 1); tick();
    tests++; if (inst_o !== SUB) begin fails++; $display("FAIL sub_inst: got %0d want %0d", inst_o, SUB); end
    tests++; if (operand_a_o !== 32'h10 || operand_b_o !== 32'h7 || rd_o !== 5'd1) begin fails++;
      $display("FAIL sub_bypass: got a=%h b=%h rd=%0d want 10/7/1", operand_a_o, operand_b_o, rd_o); end
  endtask

  task automatic test_srai_sext();
    set_in(1, 32'h41F0D093, 0, 5'd0, 32'd0, 1); tick();
    tests++; if (inst_o !== SRAI || operand_b_o !== 32'h1F || operand_a_o !== 32'd0) begin fails++;
      $display("FAIL srai: got inst=%0d a=%h b=%h want %0d/0/1f", inst_o, operand_a_o, operand_b_o, SRAI); end
    set_in(1, 32'hFFF00093, 0, 5'd0, 32'd0, 1); tick();
    tests++; if (inst_o !== ADDI || operand_b_o !== 32'hFFFF_FFFF || rd_o !== 5'd1) begin fails++;
      $display("FAIL addi_sext: got inst=%0d b=%h rd=%0d want %0d/ffffffff/1", inst_o, operand_b_o, rd_o, ADDI); end
  endtask

  task automatic test_backpressure();
    // addi x1,x3,5 reads x3, which holds 7 after the bypass scenario committed it
    set_in(1, 32'h00518093, 0, 5'd0, 32'd0, 1); tick();
    tests++; if (valid_o !== 1'b1 || inst_o !== ADDI || operand_a_o !== 32'd7) begin fails++;
      $display("FAIL bp_first: got valid=%0b inst=%0d a=%h want 1/%0d/7", valid_o, inst_o, operand_a_o, ADDI); end
    for (int c = 0; c < 3; c++) begin
      set_in(1, 32'h00A00113, 1, 5'd3, 32'h99 + 32'(c), 0);
      #1;
      tests++; if (instr_ready_o !== 1'b0) begin fails++; $display("FAIL bp_ready_%0d: got %0b want 0", c, instr_ready_o); end
      tick();
      tests++; if (valid_o !== 1'b1 || inst_o !== ADDI || operand_a_o !== 32'd7 || operand_b_o !== 32'd5 || rd_o !== 5'd1) begin
        fails++;
        $display("FAIL bp_hold_%0d: got valid=%0b inst=%0d a=%h b=%h rd=%0d want 1/%0d/7/5/1",
                 c, valid_o, inst_o, operand_a_o, operand_b_o, rd_o, ADDI);
      end
    end
    set_in(1, 32'h00A00113, 0, 5'd0, 32'd0, 1);
    #1;
    tests++; if (instr_ready_o !== 1'b1) begin fails++; $display("FAIL bp_release_ready: got %0b want 1", instr_ready_o); end
    tick();
    tests++; if (valid_o !== 1'b1 || inst_o !== ADDI || operand_b_o !== 32'd10 || rd_o !== 5'd2) begin fails++;
      $display("FAIL bp_next: got valid=%0b inst=%0d b=%h rd=%0d want 1/%0d/a/2", valid_o, inst_o, operand_b_o, rd_o, ADDI); end
  endtask

  task automatic test_illegal_x0();
    set_in(1, 32'h0000006F, 0, 5'd0, 32'd0, 1); tick();
    tests++; if (valid_o !== 1'b1 || inst_o !== ILLEGAL || operand_a_o !== 32'd0 || operand_b_o !== 32'd0 || rd_o !== 5'd0) begin
      fails++;
      $display("FAIL jal_illegal: got valid=%0b inst=%0d a=%h b=%h rd=%0d want 1/%0d/0/0/0",
               valid_o, inst_o, operand_a_o, operand_b_o, rd_o, ILLEGAL);
    end
    set_in(0, 32'd0, 1, 5'd0, 32'hDEAD, 1); tick();
    // add x1,x0,x0 while another x0 write-back is in flight
    set_in(1, 32'h000000B3, 1, 5'd0, 32'hDEAD, 1); tick();
    tests++; if (inst_o !== ADD || operand_a_o !== 32'd0 || operand_b_o !== 32'd0) begin fails++;
      $display("FAIL x0_read: got inst=%0d a=%h b=%h want %0d/0/0", inst_o, operand_a_o, operand_b_o, ADD); end
  endtask

  task automatic test_random();
    logic [31:0] ins, wdat;
    logic [4:0]  wrd;
    decoded_t    exp;
    bit          iv, rdy, wbe, acc;
    rst_i = 1'b1; #3; rst_i = 1'b0;
    for (int i = 0; i < 32; i++) rf_m[i] = 32'd0;
    m_valid  = 1'b0;
    m_bundle = '{inst: ILLEGAL, operand_a: 32'd0, operand_b: 32'd0, rd: 5'd0};
    for (int n = 0; n < 400; n++) begin
      iv   = ($urandom_range(0, 3) != 0);
      rdy  = ($urandom_range(0, 3) != 0);
      wbe  = ($urandom_range(0, 1) != 0);
      wrd  = 5'($urandom_range(0, 7));
      wdat = $urandom;
      gen(wbe, wrd, wdat, ins, exp);
      set_in(iv, ins, wbe, wrd, wdat, rdy);
      #1;
      tests++; if (instr_ready_o !== (!m_valid || rdy)) begin fails++;
        $display("FAIL rand_ready[%0d]: got %0b want %0b", n, instr_ready_o, (!m_valid || rdy)); end
      acc = iv && (!m_valid || rdy);
      if (acc) begin
        m_valid  = 1'b1;
        m_bundle = exp;
      end else if (rdy) begin
        m_valid = 1'b0;
      end
      if (wbe && wrd != 5'd0) rf_m[wrd] = wdat;
      tick();
      tests++; if (valid_o !== m_valid) begin fails++;
        $display("FAIL rand_valid[%0d]: got %0b want %0b", n, valid_o, m_valid); end
      if (m_valid) begin
        tests++;
        if (inst_o !== m_bundle.inst || operand_a_o !== m_bundle.operand_a ||
            operand_b_o !== m_bundle.operand_b || rd_o !== m_bundle.rd) begin
          fails++;
          $display("FAIL rand_bundle[%0d] ins=%h: got inst=%0d a=%h b=%h rd=%0d want inst=%0d a=%h b=%h rd=%0d",
                   n, ins, inst_o, operand_a_o, operand_b_o, rd_o,
                   m_bundle.inst, m_bundle.operand_a, m_bundle.operand_b, m_bundle.rd);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    set_in(0, 32'd0, 0, 5'd0, 32'd0, 1); tick();
    set_in(0, 32'd0, 1, 5'd5, 32'h1234, 1); tick();
    // add x7,x5,x0 accepted with execute stalled
    set_in(1, 32'h000283B3, 0, 5'd0, 32'd0, 0); tick();
    tests++; if (valid_o !== 1'b1 || inst_o !== ADD || operand_a_o !== 32'h1234 || rd_o !== 5'd7) begin fails++;
      $display("FAIL mr_before: got valid=%0b inst=%0d a=%h rd=%0d want 1/%0d/1234/7", valid_o, inst_o, operand_a_o, rd_o, ADD); end
    set_in(0, 32'd0, 0, 5'd0, 32'd0, 0);
    #2;
    rst_i = 1'b1;
    #1;
    tests++; if (valid_o !== 1'b0 || inst_o !== ILLEGAL || operand_a_o !== 32'd0 || rd_o !== 5'd0) begin fails++;
      $display("FAIL mr_async: got valid=%0b inst=%0d a=%h rd=%0d want 0/%0d/0/0", valid_o, inst_o, operand_a_o, rd_o, ILLEGAL); end
    tick();
    rst_i = 1'b0;
    set_in(1, 32'h000283B3, 0, 5'd0, 32'd0, 1); tick();
    tests++; if (valid_o !== 1'b1 || inst_o !== ADD || operand_a_o !== 32'd0) begin fails++;
      $display("FAIL mr_rf_cleared: got valid=%0b inst=%0d a=%h want 1/%0d/0", valid_o, inst_o, operand_a_o, ADD); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_sub_bypass();
    test_srai_sext();
    test_backpressure();
    test_illegal_x0();
    test_random();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
